// File: rtl/reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter
//
// Round-robin arbiter and write sequencer for one shared W-bit register.
// N requesters raise a level request; one at a time is granted, and on the
// following cycle the granted lane's data is written into the shared
// register and an ack pulse is returned to that lane.
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   defined   - a granted requester holding lock_i[g] and req_i[g] during
//               the ack cycle keeps the grant and writes again every 2 cycles.
//   undefined - lock_i is ignored; every write returns to IDLE.
//
// Ports:
//   clk_i     rising-edge clock
//   reset_ni  asynchronous active-low reset, clears all state
//   req_i     [N]    per-requester write request (level, held until ack)
//   data_i    [N*W]  requester i drives data_i[i*W +: W]
//   lock_i    [N]    per-requester burst hold (ARB_LOCK_EN only)
//   grant_o   [N]    registered one-hot grant, zero when idle
//   ack_o     [N]    one-cycle one-hot pulse on the write cycle
//   q_o       [W]    shared register contents
//   busy_o           high while in GRANT or ACK
// ---------------------------------------------------------------------------
module reg_share_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   input  logic [N-1:0]   req_i,
   input  logic [N*W-1:0] data_i,
   input  logic [N-1:0]   lock_i,
   output logic [N-1:0]   grant_o,
   output logic [N-1:0]   ack_o,
   output logic [W-1:0]   q_o,
   output logic           busy_o
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_ACK   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [N-1:0]  ack_q,   ack_d;
   logic [W-1:0]  q_q,     q_d;
   logic [IW-1:0] last_q,  last_d;   // index of the most recent writer
   logic [IW-1:0] gidx_q,  gidx_d;   // index of the current grant holder

   logic [IW-1:0] win_idx;
   logic          win_vld;
   logic [W-1:0]  gdata;

`ifndef ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^lock_i;
`endif

   // Round-robin search: candidates are last+1, last+2, ... last+N (mod N).
   // Walking the offsets from farthest to nearest lets the nearest set bit
   // overwrite the others, so no early loop exit is needed.
   always_comb begin
      logic [IW-1:0] cand;
      win_idx = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(last_q) + k) % N);
         if (req_i[cand]) begin
            win_idx = cand;
            win_vld = 1'b1;
         end
      end
   end

   // Only the grant holder's lane is ever looked at.
   always_comb begin
      gdata = '0;
      for (int i = 0; i < N; i++) begin
         if (gidx_q == IW'(i)) gdata = data_i[i*W +: W];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         last_q  <= IW'(N - 1);
         gidx_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         last_q  <= last_d;
         gidx_q  <= gidx_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ack_d   = '0;
      q_d     = q_q;
      last_d  = last_q;
      gidx_d  = gidx_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               gidx_d  = win_idx;
               grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (req_i[gidx_q]) begin
               q_d     = gdata;
               ack_d   = grant_q;
               last_d  = gidx_q;
               state_d = S_ACK;
            end else begin
               // Requester withdrew: abort without touching q or last.
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         S_ACK: begin
            grant_d = '0;
            state_d = S_IDLE;
`ifdef ARB_LOCK_EN
            // Burst: keep ownership and go straight back to the write cycle.
            if (lock_i[gidx_q] && req_i[gidx_q]) begin
               grant_d = grant_q;
               state_d = S_GRANT;
            end
`endif
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs: all driven from registers only.
   always_comb begin
      grant_o = grant_q;
      ack_o   = ack_q;
      q_o     = q_q;
      busy_o  = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_share_arbiter
//
// Scoreboard bench: a transaction-level model predicts which requester is
// granted and what each write delivers; expectations go into queues and a
// monitor pops them whenever the DUT shows a new grant or an ack.
// ---------------------------------------------------------------------------
module tb_reg_share_arbiter;
   localparam int N = 4;
   localparam int W = 8;
`ifdef ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req   = '0;
   logic [N-1:0]   lock  = '0;
   logic [N*W-1:0] data  = '0;
   logic [N-1:0]   grant, ack;
   logic [W-1:0]   q;
   logic           busy;

   int tests = 0;
   int fails = 0;

   reg_share_arbiter #(.N(N), .W(W)) dut (
      .clk_i(clk), .reset_ni(rst_n), .req_i(req), .data_i(data),
      .lock_i(lock), .grant_o(grant), .ack_o(ack), .q_o(q), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // m_phase: 0 nobody owns the register, 1 owner granted awaiting its write,
   // 2 owner's write has just landed (ack visible).
   int           m_phase = 0;
   int           m_owner = 0;
   int           m_last  = N - 1;
   logic [W-1:0] m_q     = '0;
   int           exp_grant[$];
   int           exp_wr_idx[$];
   logic [W-1:0] exp_wr_dat[$];

   function automatic logic [N-1:0] oh(int i);
      return N'(1) << i;
   endfunction

   function automatic bit bit_of(logic [N-1:0] v, int i);
      logic [N-1:0] s;
      s = v >> i;
      return s[0];
   endfunction

   function automatic int rr_pick(logic [N-1:0] r, int last);
      for (int k = 1; k <= N; k++)
         if (bit_of(r, (last + k) % N)) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [W-1:0] lane(logic [N*W-1:0] d, int i);
      logic [N*W-1:0] s;
      s = d >> (i * W);
      return s[W-1:0];
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_last = N - 1; m_q = '0;
            exp_grant.delete(); exp_wr_idx.delete(); exp_wr_dat.delete();
         end else if (m_phase == 0) begin
            int w;
            w = rr_pick(req, m_last);
            if (w >= 0) begin
               m_owner = w; m_phase = 1;
               exp_grant.push_back(w);
            end
         end else if (m_phase == 1) begin
            if (bit_of(req, m_owner)) begin
               m_q = lane(data, m_owner);
               m_last = m_owner;
               exp_wr_idx.push_back(m_owner);
               exp_wr_dat.push_back(m_q);
               m_phase = 2;
            end else begin
               m_phase = 0;
            end
         end else begin
            m_phase = (LOCK_EN && bit_of(lock, m_owner) && bit_of(req, m_owner)) ? 1 : 0;
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [N-1:0] prev_grant;
      prev_grant = '0;
      forever begin
         @(negedge clk);
         check("busy",  32'(busy),  32'(m_phase != 0));
         check("grant", 32'(grant), 32'((m_phase != 0) ? oh(m_owner) : '0));
         check("ack",   32'(ack),   32'((m_phase == 2) ? oh(m_owner) : '0));
         check("q",     32'(q),     32'(m_q));
         if (grant != '0 && prev_grant == '0) begin
            if (exp_grant.size() == 0) check("sb_grant_unexpected", 32'(grant), 32'h0);
            else check("sb_grant", 32'(grant), 32'(oh(exp_grant.pop_front())));
         end
         if (ack != '0) begin
            if (exp_wr_idx.size() == 0) check("sb_write_unexpected", 32'(ack), 32'h0);
            else begin
               check("sb_ack", 32'(ack), 32'(oh(exp_wr_idx.pop_front())));
               check("sb_data", 32'(q), 32'(exp_wr_dat.pop_front()));
            end
         end
         prev_grant = grant;
      end
   end

   // ---------------- stimulus ----------------
   task automatic rand_step();
      for (int i = 0; i < N; i++) begin
         if (bit_of(req, i)) begin
            if ($urandom_range(3) == 0) req = req & ~oh(i);
         end else if ($urandom_range(2) == 0) req = req | oh(i);
      end
      lock = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) data = (data << W) | (N*W)'($urandom_range(0, (1 << W) - 1));
   endtask

   // mode 1: one-shot (bit cleared for good once acked)
   // mode 2: random traffic
   // mode 3: persistent requester that drops its bit only on the ack cycle
   // other:  hold inputs
   task automatic drive(int n, int mode);
      logic [N-1:0] base;
      base = req;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         case (mode)
            1: begin base = base & ~ack; req = base; end
            2: rand_step();
            3: req = base & ~ack;
            default: ;
         endcase
      end
   endtask

   // kind 0: grant held without ack (write cycle pending); 1: ack seen; 2: idle
   task automatic wait_until(string name, int kind, int budget);
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < budget && !hit; c++) begin
         @(negedge clk);
         case (kind)
            0: hit = (grant != '0) && (ack == '0);
            1: hit = (ack != '0);
            default: hit = !busy;
         endcase
      end
      if (!hit) begin
         tests++; fails++;
         $display("FAIL %s: timeout after %0d cycles", name, budget);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive(2, 4);

      // single write on lane 2
      data = N*W'(32'h1122_3344); data[23:16] = 8'hC3;
      req = 4'b0100;
      drive(6, 1);
      check("single_q", 32'(q), 32'hC3);

      // round robin with all lanes requesting
      data = N*W'(32'hD4C3B2A1);
      req = 4'b1111;
      drive(30, 3);
      req = '0; drive(4, 4);

      // abort: lane 1 withdraws while granted
      q_before_abort: begin
         logic [W-1:0] qb;
         qb = q;
         req = 4'b0010;
         wait_until("abort_grant", 0, 10);
         req = '0;
         drive(4, 4);
         check("abort_q_kept", 32'(q), 32'(qb));
      end

      // late request arriving during ack of lane 0
      req = 4'b0001;
      wait_until("late_ack0", 1, 10);
      req = 4'b0100;
      drive(8, 1);

      // lock burst on lane 3 with lane 0 also requesting
      lock = 4'b1000; req = 4'b1001;
      drive(12, 4);
      lock = '0;
      drive(12, 3);
      req = '0; drive(4, 4);

      // randomized traffic
      drive(3000, 2);
      req = '0; lock = '0;
      drive(6, 4);

      // reset while in the write-pending state
      data[7:0] = 8'h5A;
      req = 4'b0001;
      wait_until("pre_reset_ack", 1, 10);
      req = '0;
      drive(3, 4);
      check("pre_reset_q", 32'(q), 32'h5A);
      req = 4'b0001;
      wait_until("pre_reset_grant", 0, 10);
      #2 rst_n = 1'b0;
      #1;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_ack",   32'(ack),   32'h0);
      check("rst_q",     32'(q),     32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(8, 4);

      check("sb_grant_drained", 32'(exp_grant.size()), 32'h0);
      check("sb_write_drained", 32'(exp_wr_idx.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
